// File: rtl/cpu7_exu_ifu_rcv.sv
// EXU-side receiver for IFU decoded bundles: 2-entry skid FIFO with registered ready.
// Optional stall counter enabled by defining CPU7_EXU_IFU_RCV_PERF_EN.
module cpu7_exu_ifu_rcv #(
  parameter int unsigned GRLEN = 32,
  parameter int unsigned OP_W  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifu_exu_valid_d,
  output logic             exu_ifu_ready,
  input  logic [31:0]      ifu_exu_inst_d,
  input  logic [GRLEN-1:0] ifu_exu_pc_d,
  input  logic [OP_W-1:0]  ifu_exu_op_d,
  input  logic [31:0]      ifu_exu_imm_shifted_d,
  input  logic [GRLEN-1:0] ifu_exu_c_d_d,
  input  logic             ifu_exu_use_imm_d,
  input  logic [GRLEN-1:0] ifu_exu_rdata1_d,
  input  logic [GRLEN-1:0] ifu_exu_rdata2_d,
  input  logic             exu_flush,
  output logic             exu_e_valid,
  input  logic             exu_e_ready,
  output logic [31:0]      exu_e_inst,
  output logic [GRLEN-1:0] exu_e_pc,
  output logic [OP_W-1:0]  exu_e_op,
  output logic [GRLEN-1:0] exu_e_src_a,
  output logic [GRLEN-1:0] exu_e_src_b,
  output logic [GRLEN-1:0] exu_e_c
`ifdef CPU7_EXU_IFU_RCV_PERF_EN
  ,
  output logic [31:0]      exu_perf_stall_cnt
`endif
);

  localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

  logic [31:0]      r_inst  [2];
  logic [GRLEN-1:0] r_pc    [2];
  logic [OP_W-1:0]  r_op    [2];
  logic [GRLEN-1:0] r_src_a [2];
  logic [GRLEN-1:0] r_src_b [2];
  logic [GRLEN-1:0] r_c     [2];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_count;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic             w_ready_nxt;
  logic [GRLEN-1:0] w_imm_ext;
  logic [GRLEN-1:0] w_src_b;

  generate
    if (GRLEN > 32) begin : g_imm_sext
      assign w_imm_ext = {{(GRLEN-32){ifu_exu_imm_shifted_d[31]}}, ifu_exu_imm_shifted_d};
    end else begin : g_imm_direct
      assign w_imm_ext = ifu_exu_imm_shifted_d[GRLEN-1:0];
    end
  endgenerate

  // Operand B is resolved once at push so the output path is a plain mux on rp.
  assign w_src_b = ifu_exu_use_imm_d ? w_imm_ext : ifu_exu_rdata2_d;

  assign w_push = ifu_exu_valid_d & r_ready;
  assign w_pop  = exu_e_valid & exu_e_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (exu_flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
    w_ready_nxt = (w_count_nxt < LP_DEPTH) & ~exu_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_inst[i]  <= '0;
        r_pc[i]    <= '0;
        r_op[i]    <= '0;
        r_src_a[i] <= '0;
        r_src_b[i] <= '0;
        r_c[i]     <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      r_ready <= w_ready_nxt;
      if (exu_flush) begin
        r_wp <= 1'b0;
        r_rp <= 1'b0;
      end else begin
        if (w_push) begin
          r_inst[r_wp]  <= ifu_exu_inst_d;
          r_pc[r_wp]    <= ifu_exu_pc_d;
          r_op[r_wp]    <= ifu_exu_op_d;
          r_src_a[r_wp] <= ifu_exu_rdata1_d;
          r_src_b[r_wp] <= w_src_b;
          r_c[r_wp]     <= ifu_exu_c_d_d;
          r_wp          <= ~r_wp;
        end
        if (w_pop) begin
          r_rp <= ~r_rp;
        end
      end
    end
  end

  assign exu_ifu_ready = r_ready;
  assign exu_e_valid   = (r_count != 2'd0);
  assign exu_e_inst    = r_inst[r_rp];
  assign exu_e_pc      = r_pc[r_rp];
  assign exu_e_op      = r_op[r_rp];
  assign exu_e_src_a   = r_src_a[r_rp];
  assign exu_e_src_b   = r_src_b[r_rp];
  assign exu_e_c       = r_c[r_rp];

`ifdef CPU7_EXU_IFU_RCV_PERF_EN
  logic [31:0] r_stall_cnt;

  // Counts cycles the IFU offers a bundle we cannot take; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (ifu_exu_valid_d && !r_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign exu_perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/cpu7_exu_ifu_rcv.md
Name: cpu7_exu_ifu_rcv

Overview:
- EXU-side receiving end of the IFU→EXU decoded-instruction interface.
- Accepts each decoded bundle from the IFU: instruction word, PC, op vector, shifted immediate, auxiliary constant C, and the register-file operand read for it.
- Buffers bundles in a 2-entry skid FIFO so the IFU sees a registered ready.
- Presents one bundle per cycle to the execute stage, with operand B already resolved to either the immediate or the register value.

Parameters:
- GRLEN, 32, datapath width for PC, operands and C.
- OP_W, 64, width of the decoded op vector; the vector is carried opaquely.
- DEPTH, 2, FIFO entries; fixed at 2, and other values are not supported.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ifu_exu_valid_d  input  1  bundle valid from IFU.
- exu_ifu_ready  output  1  receiver can accept a bundle this cycle.
- ifu_exu_inst_d  input  32  raw instruction word.
- ifu_exu_pc_d  input  GRLEN  instruction PC.
- ifu_exu_op_d  input  OP_W  decoded op vector.
- ifu_exu_imm_shifted_d  input  32  immediate, already extended and shifted.
- ifu_exu_c_d_d  input  GRLEN  auxiliary constant (count flag, shift amount, msb/lsb field).
- ifu_exu_use_imm_d  input  1  operand B comes from the immediate.
- ifu_exu_rdata1_d  input  GRLEN  register-file port 1 data.
- ifu_exu_rdata2_d  input  GRLEN  register-file port 2 data.
- exu_flush  input  1  pipeline flush (exception/branch redirect).
- exu_e_valid  output  1  head bundle valid to execute stage.
- exu_e_ready  input  1  execute stage consumes head this cycle.
- exu_e_inst  output  32  head instruction.
- exu_e_pc  output  GRLEN  head PC.
- exu_e_op  output  OP_W  head op vector.
- exu_e_src_a  output  GRLEN  head operand A (= rdata1).
- exu_e_src_b  output  GRLEN  head operand B.
- exu_e_c  output  GRLEN  head constant C.

Behaviour:
- Storage:
  - Two entries; 1-bit write pointer wp, 1-bit read pointer rp, 2-bit count (0..2).
  - Both pointers wrap 1→0.
- Push and pop:
  - push = ifu_exu_valid_d & exu_ifu_ready.
  - pop = exu_e_valid & exu_e_ready.
- Ready:
  - exu_ifu_ready is registered: next value = (next_count < 2) & !exu_flush.
  - Reset value 1.
  - Ready therefore never depends combinationally on exu_e_ready.
- Operand B resolution at push:
  - src_b = use_imm ? {{(GRLEN-32){imm[31]}}, imm} : rdata2.
  - The resolved value is stored, not recomputed at output. For GRLEN=32 no extension is applied.
- Outputs:
  - exu_e_* outputs are driven from entry[rp].
  - exu_e_valid = (count != 0).
  - Latency is one cycle: a bundle pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no combinational bypass.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Boundary conditions:
  - count=2: ready is 0, so push is impossible; a pop alone makes ready 1 in the next cycle.
  - count=1 with push and pop in the same cycle: the old head leaves, the new entry becomes head next cycle, count stays 1.
  - count=0 with exu_e_ready=1: no pop; the data outputs hold their last values and only valid gates them.
- Flush:
  - On exu_flush, the next cycle has count=0, wp=rp=0, exu_e_valid=0 and exu_ifu_ready=0.
  - Any push or pop in the flush cycle is discarded.
  - Ready returns to 1 in the cycle after that.
- Reset:
  - count, pointers, exu_e_valid and all entry data are cleared to 0; exu_ifu_ready is 1.
  - Reset asserted mid-operation discards all buffered bundles.
  - Reset has priority over exu_flush.
- Ordering: strict FIFO; bundles are never reordered or duplicated.

Optional Feature:
- Macro: CPU7_EXU_IFU_RCV_PERF_EN.
- When defined:
  - Adds output exu_perf_stall_cnt (32 bits).
  - The counter increments each cycle where ifu_exu_valid_d=1 and exu_ifu_ready=0.
  - It saturates at 0xFFFFFFFF, clears on reset, and is not affected by flush.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then push one bundle (pc=0x1c000000, use_imm=1, imm=0xFFFFF800) with exu_e_ready=1 → exu_e_valid=1 the next cycle with src_b=0xFFFFF800; count returns to 0 the cycle after.
- Push with use_imm=0, rdata2=0x12345678, imm=0x7 → exu_e_src_b=0x12345678.
- Hold exu_e_ready=0 and push 3 back-to-back bundles → the first two are accepted, exu_ifu_ready=0 from the cycle after the second push; release ready → outputs appear in order A, B, then C is accepted.
- Hold count=1 with continuous push and pop for 10 cycles → count stays 1, exu_ifu_ready stays 1, and each output follows its input by one cycle.
- With count=2, assert exu_flush for 1 cycle together with a push attempt → next cycle exu_e_valid=0 and ready=0; the cycle after, ready=1 and no stale bundle appears.
- With PERF_EN defined: 4 cycles of valid while full → exu_perf_stall_cnt=4; assert reset → counter is 0.
